mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-client to one-port memory arbiter sitting directly downstream of the RV32I core's split instruction/data memory interface. It accepts instruction fetches and data loads/stores from the core, serializes them onto a single physical memory port, and routes each response back to the requesting side. A registered three-state FSM with latched request fields keeps memory-side outputs stable for the whole transaction.

## Interface
Parameters:
- ADDR_W, 32, address width (both clients and memory)
- DATA_W, 32, data width; mbe width is DATA_W/8

Ports:
- clk  input  1  single clock, all state rising-edge
- rst  input  1  asynchronous, active-high reset
- inst_read  input  1  fetch request, held until inst_resp
- inst_addr  input  ADDR_W  fetch address
- inst_resp  output  1  one-cycle fetch-complete pulse
- inst_rdata  output  DATA_W  fetch data, valid when inst_resp
- data_read  input  1  load request, held until data_resp
- data_write  input  1  store request, held until data_resp
- data_mbe  input  DATA_W/8  store byte enables
- data_addr  input  ADDR_W  load/store address
- data_wdata  input  DATA_W  store data
- data_resp  output  1  one-cycle load/store-complete pulse
- data_rdata  output  DATA_W  load data, valid when data_resp
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- mem_mbe  output  DATA_W/8  memory byte enables
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_resp  input  1  memory completion pulse
- mem_rdata  input  DATA_W  memory read data, valid with mem_resp

## Operation
- States: IDLE, SERVE_I, SERVE_D. Reset -> IDLE.
- IDLE: samples requests. data_read|data_write and inst_read both high -> grant per arbitration policy (see Configuration). Only one high -> grant it. Grant latches addr, wdata, mbe, read/write into registers; next state SERVE_I/SERVE_D.
- data_read and data_write both high: illegal; arbiter treats as write.
- Instruction grant: mem_read=1, mem_write=0, mem_mbe=4'b0000 (all zeros), mem_addr=latched inst_addr.
- Data grant: mem_read/mem_write from latched data_read/data_write, mem_addr/mem_wdata/mem_mbe latched.
- SERVE_x: holds memory outputs constant until mem_resp. On mem_resp: x_resp=1 combinationally that cycle, x_rdata=mem_rdata; next state IDLE.
- Non-granted client's resp stays 0; its rdata is don't-care (drive mem_rdata).
- mem_resp in IDLE: ignored, no client resp.
- Client changes addr/data mid-transaction: ignored (latched copy used).

## Timing
- Reset values: state IDLE; mem_read=0, mem_write=0, mem_mbe=0, mem_addr=0, mem_wdata=0, inst_resp=0, data_resp=0. Reset asserted mid-transaction clears state and strobes immediately (asynchronously); in-flight memory response is discarded; memory must tolerate abandoned request.
- Request seen in IDLE at cycle t -> memory strobe at t+1 -> mem_resp at t+k (k>=1) -> client resp at t+k -> IDLE at t+k+1. Minimum request-to-resp latency 2 cycles; one dead IDLE cycle between back-to-back transactions.
- Client request still high in the cycle after its resp is treated as a new request.
- Memory strobes are registered outputs; client resp is combinational from mem_resp and state.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on simultaneous inst/data requests in IDLE, grant alternates; one-bit last_grant register (reset = instruction, so data wins first tie) updated on every grant.
- Not defined: fixed priority, data always wins ties; no last_grant register.

## Test plan
- Lone fetch: inst_read=1, inst_addr=0x60, mem_resp at 3rd cycle with mem_rdata=0x00000013 -> mem_read=1 addr 0x60 from t+1, inst_resp pulse with inst_rdata=0x00000013, data_resp=0.
- Lone store: data_write=1, addr=0x100, wdata=0xDEADBEEF, mbe=0b0011 -> mem_write=1 with those exact fields, mem_read=0, data_resp on mem_resp, then IDLE.
- Simultaneous fetch + load, held across three transactions -> fixed priority: D then D-never-completes-I until data drops; round-robin build: D, I, D grant order.
- Client alters inst_addr 0x60->0x64 while SERVE_I -> mem_addr stays 0x60 until mem_resp.
- rst asserted during SERVE_D with mem_write high -> mem_write=0 same cycle (async), state IDLE, no data_resp, late mem_resp ignored.
- Stray mem_resp=1 while IDLE with no requests -> inst_resp=data_resp=0, state unchanged.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - client and memory-port signals of mem_port_arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  inst_read;
  logic [ADDR_W-1:0]     inst_addr;
  logic                  inst_resp;
  logic [DATA_W-1:0]     inst_rdata;
  logic                  data_read;
  logic                  data_write;
  logic [DATA_W/8-1:0]   data_mbe;
  logic [ADDR_W-1:0]     data_addr;
  logic [DATA_W-1:0]     data_wdata;
  logic                  data_resp;
  logic [DATA_W-1:0]     data_rdata;
  logic                  mem_read;
  logic                  mem_write;
  logic [DATA_W/8-1:0]   mem_mbe;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_resp;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  inst_read, inst_addr, data_read, data_write, data_mbe, data_addr, data_wdata,
           mem_resp, mem_rdata,
    output inst_resp, inst_rdata, data_resp, data_rdata,
           mem_read, mem_write, mem_mbe, mem_addr, mem_wdata
  );

  modport master (
    output inst_read, inst_addr, data_read, data_write, data_mbe, data_addr, data_wdata,
           mem_resp, mem_rdata,
    input  inst_resp, inst_rdata, data_resp, data_rdata,
           mem_read, mem_write, mem_mbe, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - serializes RV32I fetch and load/store requests onto one memory port
// Define ARB_ROUND_ROBIN_EN for alternating grants on ties; default is fixed data priority.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  mem_port_arbiter_if.slave bus
);
  localparam int MBE_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t              state;
  state_t              state_nxt;
  logic                data_req;
  logic                grant_i;
  logic                grant_d;
  logic                mem_read_q;
  logic                mem_write_q;
  logic [MBE_W-1:0]    mem_mbe_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;

  assign data_req = bus.data_read | bus.data_write;

`ifdef ARB_ROUND_ROBIN_EN
  // last_grant_d = 1 when the most recent grant went to the data side
  logic last_grant_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_grant_d <= 1'b0;
    else if (grant_i | grant_d)
      last_grant_d <= grant_d;
  end

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE) begin
      if (data_req && bus.inst_read) begin
        grant_d = ~last_grant_d;
        grant_i = last_grant_d;
      end else begin
        grant_d = data_req;
        grant_i = bus.inst_read;
      end
    end
  end
`else
  assign grant_d = (state == IDLE) && data_req;
  assign grant_i = (state == IDLE) && bus.inst_read && !data_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_mbe_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state <= state_nxt;
      // A simultaneous read+write from the data side is resolved as a write
      if (grant_d) begin
        mem_read_q  <= bus.data_read & ~bus.data_write;
        mem_write_q <= bus.data_write;
        mem_mbe_q   <= bus.data_mbe;
        mem_addr_q  <= bus.data_addr;
        mem_wdata_q <= bus.data_wdata;
      end else if (grant_i) begin
        mem_read_q  <= 1'b1;
        mem_write_q <= 1'b0;
        mem_mbe_q   <= '0;
        mem_addr_q  <= bus.inst_addr;
      end else if (state != IDLE && bus.mem_resp) begin
        mem_read_q  <= 1'b0;
        mem_write_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_d)
          state_nxt = SERVE_D;
        else if (grant_i)
          state_nxt = SERVE_I;
      end
      SERVE_I, SERVE_D: begin
        if (bus.mem_resp)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.inst_resp  = (state == SERVE_I) && bus.mem_resp;
    bus.data_resp  = (state == SERVE_D) && bus.mem_resp;
    bus.inst_rdata = bus.mem_rdata;
    bus.data_rdata = bus.mem_rdata;
    bus.mem_read   = mem_read_q;
    bus.mem_write  = mem_write_q;
    bus.mem_mbe    = mem_mbe_q;
    bus.mem_addr   = mem_addr_q;
    bus.mem_wdata  = mem_wdata_q;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        inst_read;
    logic [31:0] inst_addr;
    logic        data_read;
    logic        data_write;
    logic [3:0]  mbe;
    logic [31:0] data_addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    logic        exp_d;
  } vec_t;

  typedef struct {
    logic        d;
    logic        rd;
    logic        wr;
    logic [3:0]  mbe;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  logic model_last_d = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, req);
  endtask

  function automatic logic pick_d(input logic i, input logic d, input logic fixed_d);
    logic r;
`ifdef ARB_ROUND_ROBIN_EN
    r = (i && d) ? !model_last_d : d;
`else
    r = (i && d) ? fixed_d : d;
`endif
    model_last_d = r;
    return r;
  endfunction

  function automatic exp_t make_exp(input vec_t v, input logic d);
    exp_t e;
    e.d     = d;
    e.rd    = d ? (v.data_read & ~v.data_write) : 1'b1;
    e.wr    = d ? v.data_write : 1'b0;
    e.mbe   = d ? v.mbe : 4'h0;
    e.addr  = d ? v.data_addr : v.inst_addr;
    e.wdata = v.wdata;
    e.rdata = v.rdata;
    return e;
  endfunction

  task automatic clear_reqs();
    bus.inst_read  = 1'b0;
    bus.data_read  = 1'b0;
    bus.data_write = 1'b0;
  endtask

  task automatic wait_strobe(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.mem_read | bus.mem_write) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    exp_t got;
    @(posedge clk); #1;
    bus.inst_read  = v.inst_read;
    bus.inst_addr  = v.inst_addr;
    bus.data_read  = v.data_read;
    bus.data_write = v.data_write;
    bus.data_mbe   = v.mbe;
    bus.data_addr  = v.data_addr;
    bus.data_wdata = v.wdata;
    e = make_exp(v, pick_d(v.inst_read, v.data_read | v.data_write, v.exp_d));
    sb.push_back(e);
    got = e;
    for (int c = 1; c <= v.lat; c++) begin
      @(posedge clk); #1;
      if (c == v.lat) begin
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = v.rdata;
      end
      @(negedge clk);
      if (c == 1) begin
        got = sb.pop_front();
        chk("vec_mem_read",  bus.mem_read,  got.rd);
        chk("vec_mem_write", bus.mem_write, got.wr);
        chk("vec_mem_mbe",   bus.mem_mbe,   got.mbe);
        chk("vec_mem_addr",  bus.mem_addr,  got.addr);
        if (got.d) chk("vec_mem_wdata", bus.mem_wdata, got.wdata);
      end
      if (c < v.lat) begin
        chk("vec_no_early_resp", bus.inst_resp | bus.data_resp, 1'b0);
      end else begin
        chk("vec_inst_resp", bus.inst_resp, !got.d);
        chk("vec_data_resp", bus.data_resp, got.d);
        if (got.d) chk("vec_data_rdata", bus.data_rdata, got.rdata);
        else       chk("vec_inst_rdata", bus.inst_rdata, got.rdata);
      end
    end
    @(posedge clk); #1;
    bus.mem_resp = 1'b0;
    clear_reqs();
    @(negedge clk);
    chk("vec_idle_strobes", {bus.mem_read, bus.mem_write}, 2'b00);
  endtask

  task automatic serve_one(input logic [31:0] rd);
    bit   ok;
    exp_t e;
    wait_strobe(ok);
    chk("tie_strobe_seen", ok, 1'b1);
    if (sb.size() == 0) begin
      chk("tie_scoreboard_nonempty", 1'b0, 1'b1);
    end else begin
      e = sb.pop_front();
      chk("tie_grant_addr", bus.mem_addr, e.addr);
      bus.mem_resp  = 1'b1;
      bus.mem_rdata = rd;
      #1;
      chk("tie_inst_resp", bus.inst_resp, !e.d);
      chk("tie_data_resp", bus.data_resp, e.d);
      @(posedge clk); #1;
      bus.mem_resp = 1'b0;
    end
  endtask

  initial begin
    bit   ok;
    exp_t e;

    vecs[0] = '{1'b1, 32'h60, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0,        3, 32'h00000013, 1'b0};
    vecs[1] = '{1'b0, 32'h0,  1'b0, 1'b1, 4'h3, 32'h100, 32'hDEADBEEF, 1, 32'h0,        1'b1};
    vecs[2] = '{1'b0, 32'h0,  1'b1, 1'b0, 4'hF, 32'h200, 32'h0,        2, 32'hCAFEF00D, 1'b1};
    vecs[3] = '{1'b0, 32'h0,  1'b1, 1'b1, 4'hC, 32'h300, 32'h12345678, 1, 32'h0,        1'b1};
    vecs[4] = '{1'b1, 32'h64, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0,        1, 32'h00100093, 1'b0};
    vecs[5] = '{1'b1, 32'h80, 1'b1, 1'b0, 4'hF, 32'h400, 32'h0,        2, 32'h55AA55AA, 1'b1};
    vecs[6] = '{1'b1, 32'h84, 1'b0, 1'b1, 4'h1, 32'h404, 32'h000000A5, 1, 32'h00000077, 1'b1};
    vecs[7] = '{1'b1, 32'h88, 1'b1, 1'b0, 4'hF, 32'h408, 32'h0,        1, 32'h00000099, 1'b1};

    clear_reqs();
    bus.inst_addr  = '0;
    bus.data_mbe   = '0;
    bus.data_addr  = '0;
    bus.data_wdata = '0;
    bus.mem_resp   = 1'b1;
    bus.mem_rdata  = 32'hFFFF_FFFF;

    repeat (2) @(negedge clk);
    chk("rst_mem_read",  bus.mem_read,  1'b0);
    chk("rst_mem_write", bus.mem_write, 1'b0);
    chk("rst_mem_mbe",   bus.mem_mbe,   4'h0);
    chk("rst_mem_addr",  bus.mem_addr,  32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_resps",     {bus.inst_resp, bus.data_resp}, 2'b00);
    rst = 1'b0;
    model_last_d = 1'b0;

    // stray memory responses while idle
    repeat (2) begin
      @(negedge clk);
      chk("stray_resps",   {bus.inst_resp, bus.data_resp}, 2'b00);
      chk("stray_strobes", {bus.mem_read, bus.mem_write}, 2'b00);
    end
    bus.mem_resp = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // fetch address changes mid-transaction
    @(posedge clk); #1;
    bus.inst_read = 1'b1;
    bus.inst_addr = 32'h60;
    e.d = pick_d(1'b1, 1'b0, 1'b0);
    wait_strobe(ok);
    chk("hold_strobe_seen", ok, 1'b1);
    chk("hold_addr_start", bus.mem_addr, 32'h60);
    bus.inst_addr = 32'h64;
    repeat (2) begin
      @(negedge clk);
      chk("hold_addr_mid", bus.mem_addr, 32'h60);
      chk("hold_no_resp",  bus.inst_resp, 1'b0);
    end
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 32'h00000013;
    #1;
    chk("hold_inst_resp",  bus.inst_resp, !e.d);
    chk("hold_inst_rdata", bus.inst_rdata, 32'h00000013);
    chk("hold_addr_end",   bus.mem_addr, 32'h60);
    @(posedge clk); #1;
    bus.mem_resp = 1'b0;
    clear_reqs();

    // asynchronous reset during a store
    @(posedge clk); #1;
    bus.data_write = 1'b1;
    bus.data_addr  = 32'h600;
    bus.data_wdata = 32'h11223344;
    bus.data_mbe   = 4'hF;
    wait_strobe(ok);
    chk("arst_strobe_seen", ok, 1'b1);
    chk("arst_write_before", bus.mem_write, 1'b1);
    rst = 1'b1;
    bus.mem_resp = 1'b1;
    #1;
    chk("arst_write_cleared", bus.mem_write, 1'b0);
    chk("arst_addr_cleared",  bus.mem_addr, 32'h0);
    chk("arst_no_data_resp",  bus.data_resp, 1'b0);
    bus.data_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_last_d = 1'b0;
    @(negedge clk);
    chk("arst_late_resp_ignored", {bus.inst_resp, bus.data_resp}, 2'b00);
    chk("arst_idle_strobes",      {bus.mem_read, bus.mem_write}, 2'b00);
    bus.mem_resp = 1'b0;

    // fetch and load held together across several transactions
    @(posedge clk); #1;
    bus.inst_read = 1'b1;
    bus.inst_addr = 32'h60;
    bus.data_read = 1'b1;
    bus.data_addr = 32'h500;
    bus.data_mbe  = 4'hF;
    for (int k = 0; k < 3; k++) begin
      e.d    = pick_d(1'b1, 1'b1, 1'b1);
      e.addr = e.d ? 32'h500 : 32'h60;
      sb.push_back(e);
    end
    for (int k = 0; k < 3; k++) serve_one(32'h1000 + k);
    bus.data_read = 1'b0;
    e.d    = pick_d(1'b1, 1'b0, 1'b0);
    e.addr = 32'h60;
    sb.push_back(e);
    serve_one(32'h2000);
    clear_reqs();
    @(negedge clk);
    chk("final_idle_strobes", {bus.mem_read, bus.mem_write}, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
